// File: rtl/level_transition_unit_pkg.sv
// Shared types and constants for the level transition unit.
// Holds the FSM state encoding, hero start-position tables and parameter defaults.
// No logic; imported by the top and the start-position ROM.
package level_transition_unit_pkg;

    // Transition sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_BANNER = 3'd2,
        ST_BONUS  = 3'd3,
        ST_WIN    = 3'd4
    } state_t;

    // Parameter defaults
    localparam int DEF_BANNER_FRAMES = 120;
    localparam int DEF_MAX_LEVEL     = 9;
    localparam int DEF_BONUS_STEP    = 100;

    // Hero start positions, indexed by level[1:0]
    localparam logic [11:0] START_X [4] = '{12'd482, 12'd130, 12'd834, 12'd482};
    localparam logic [11:0] START_Y [4] = '{12'd700, 12'd700, 12'd700, 12'd650};

endpackage

// File: rtl/level_transition_unit_level_start_rom.sv
// Hero start-position lookup for a level.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the index continuously.
module level_start_rom
    import level_transition_unit_pkg::*;
(
    input  logic [1:0]  idx,
    output logic [11:0] x,
    output logic [11:0] y
);

    // Table lookup
    always_comb begin
        x = START_X[idx];
        y = START_Y[idx];
    end

endmodule

// File: rtl/level_transition_unit.sv
// Sequences a level change: load hero, show banner for N frames, award bonus, or win.
// Latency: hero_load one clock after hero_rst (or after return to idle with a pending request).
// Backpressure: none; a hero_rst arriving mid-sequence is held in a one-deep pending flag.
module level_transition_unit
    import level_transition_unit_pkg::*;
#(
    parameter int BANNER_FRAMES = DEF_BANNER_FRAMES,
    parameter int MAX_LEVEL     = DEF_MAX_LEVEL,
    parameter int BONUS_STEP    = DEF_BONUS_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  level,
    input  logic        hero_rst,
    input  logic        frame_tick,
    output logic        hero_load,
    output logic [11:0] hero_x_init,
    output logic [11:0] hero_y_init,
    output logic        freeze,
    output logic        banner_en,
    output logic [3:0]  banner_level,
    output logic        bonus_add,
    output logic [23:0] bonus_value,
    output logic        game_won
);

    localparam int              CW         = $clog2(BANNER_FRAMES + 1);
    localparam logic [CW-1:0]   LAST_FRAME = CW'(BANNER_FRAMES - 1);
    localparam logic [23:0]     STEP24     = 24'(BONUS_STEP);

    state_t         state_q;
    state_t         state_d;
    logic           pending_q;
    logic [CW-1:0]  frame_cnt_q;
    logic [3:0]     level_q;
    logic [11:0]    x_q;
    logic [11:0]    y_q;
    logic [11:0]    rom_x;
    logic [11:0]    rom_y;
    logic           start;
    logic           above_max;

    // A new transition starts from idle on a fresh or deferred request
    assign start     = (state_q == ST_IDLE) && (hero_rst || pending_q);
    assign above_max = ({28'd0, level_q} > 32'(MAX_LEVEL));

    level_start_rom u_rom (
        .idx (level[1:0]),
        .x   (rom_x),
        .y   (rom_y)
    );

    // State register; reset parks in LOAD so the level-0 banner runs on release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   state_d = above_max ? ST_WIN : ST_BANNER;
            ST_BANNER: if (frame_tick && (frame_cnt_q == LAST_FRAME)) state_d = ST_BONUS;
            ST_BONUS:  state_d = ST_IDLE;
            ST_WIN:    state_d = ST_WIN;
            default:   state_d = ST_LOAD;
        endcase
    end

    // Pending request: set by hero_rst while busy, consumed on return to idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            pending_q <= 1'b0;
        end else if ((state_q != ST_WIN) && hero_rst) begin
            pending_q <= 1'b1;
        end
    end

    // Banner frame counter: cleared in LOAD, advanced by frame_tick in BANNER
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (state_q == ST_LOAD) begin
            frame_cnt_q <= '0;
        end else if ((state_q == ST_BANNER) && frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    // Capture level and its start position when a transition begins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 4'd0;
            x_q     <= START_X[0];
            y_q     <= START_Y[0];
        end else if (start) begin
            level_q <= level;
            x_q     <= rom_x;
            y_q     <= rom_y;
        end
    end

    // Moore outputs; hero_load is held low while reset is asserted
    always_comb begin
        hero_load    = (state_q == ST_LOAD) && rst;
        freeze       = (state_q != ST_IDLE);
        banner_en    = (state_q == ST_BANNER);
        bonus_add    = (state_q == ST_BONUS);
        bonus_value  = (state_q == ST_BONUS) ? (24'(level_q) * STEP24) : 24'd0;
        game_won     = (state_q == ST_WIN);
        banner_level = level_q;
        hero_x_init  = x_q;
        hero_y_init  = y_q;
    end

endmodule

// File: tb/tb_level_transition_unit.sv
module tb_level_transition_unit;

    localparam int FRAMES = 120;
    localparam int STEP   = 100;
    localparam int BOUND  = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  level = 4'd0;
    logic        hero_rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        hero_load;
    logic [11:0] hero_x_init;
    logic [11:0] hero_y_init;
    logic        freeze;
    logic        banner_en;
    logic [3:0]  banner_level;
    logic        bonus_add;
    logic [23:0] bonus_value;
    logic        game_won;

    int checks = 0;
    int errors = 0;

    level_transition_unit dut (
        .clk          (clk),
        .rst          (rst),
        .level        (level),
        .hero_rst     (hero_rst),
        .frame_tick   (frame_tick),
        .hero_load    (hero_load),
        .hero_x_init  (hero_x_init),
        .hero_y_init  (hero_y_init),
        .freeze       (freeze),
        .banner_en    (banner_en),
        .banner_level (banner_level),
        .bonus_add    (bonus_add),
        .bonus_value  (bonus_value),
        .game_won     (game_won)
    );

    always #5 clk = ~clk;

    // Reference start-position table
    function automatic int exp_x(input int l);
        case (l % 4)
            0: return 482;
            1: return 130;
            2: return 834;
            default: return 482;
        endcase
    endfunction

    function automatic int exp_y(input int l);
        return ((l % 4) == 3) ? 650 : 700;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, let one rising edge pass, sample in the low phase
    task automatic drive(input logic ft, input logic hr);
        frame_tick = ft;
        hero_rst   = hr;
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_level"},   banner_level, 0);
        check({tag, "_x"},       hero_x_init, 482);
        check({tag, "_y"},       hero_y_init, 700);
        check({tag, "_load"},    hero_load, 0);
        check({tag, "_freeze"},  freeze, 1);
        check({tag, "_banner"},  banner_en, 0);
        check({tag, "_bonus"},   bonus_add, 0);
        check({tag, "_bval"},    bonus_value, 0);
        check({tag, "_won"},     game_won, 0);
    endtask

    // Entered in a LOAD cycle; walks banner and bonus, ends sampled in IDLE.
    // n_pulses hero_rst pulses are injected during the banner with level=nxt_lvl;
    // bonus_pulse fires hero_rst on the bonus cycle.
    task automatic do_banner(input int lvl, input int n_pulses, input bit bonus_pulse,
                             input int nxt_lvl, output bit pend);
        int cnt;
        int cyc;
        int bad;
        logic ft;
        logic hr;
        check("load_pulse",  hero_load, 1);
        check("load_level",  banner_level, lvl);
        check("load_x",      hero_x_init, exp_x(lvl));
        check("load_y",      hero_y_init, exp_y(lvl));
        check("load_freeze", freeze, 1);
        cnt = 0;
        cyc = 0;
        bad = 0;
        drive(0, 0);
        if (!banner_en || !freeze || hero_load) bad++;
        while (cnt < FRAMES && cyc < BOUND) begin
            ft = 1'($urandom_range(0, 1));
            hr = ((cyc % 3) == 1) && ((cyc / 3) < n_pulses);
            if (hr) level = 4'(nxt_lvl);
            drive(ft, hr);
            cyc++;
            if (ft) cnt++;
            if (cnt < FRAMES) begin
                if (!banner_en || !freeze || bonus_add || hero_load) bad++;
                if (banner_level != 4'(lvl) || hero_x_init != 12'(exp_x(lvl))) bad++;
            end
        end
        check("banner_hold", bad, 0);
        check("banner_in_budget", cyc < BOUND, 1);
        check("bonus_add",    bonus_add, 1);
        check("bonus_value",  bonus_value, lvl * STEP);
        check("bonus_banner", banner_en, 0);
        check("bonus_freeze", freeze, 1);
        if (bonus_pulse) level = 4'(nxt_lvl);
        drive(1'($urandom_range(0, 1)), bonus_pulse);
        check("idle_freeze", freeze, 0);
        check("idle_bonus",  bonus_add, 0);
        check("idle_load",   hero_load, 0);
        pend = (n_pulses > 0) || bonus_pulse;
    endtask

    initial begin
        bit p;
        int bad;
        int lvl;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset("rst0");

        // Release: level-0 banner without hero_rst
        @(negedge clk);
        rst = 1'b1;
        #1;
        do_banner(0, 0, 0, 0, p);
        drive(0, 0);
        check("idle_stays", hero_load, 0);

        // Level 3, second request (level 4) during its banner
        level = 4'd3;
        drive(0, 1);
        do_banner(3, 1, 0, 4, p);
        check("pend_after_3", p, 1);
        drive(0, 0);
        // Three requests during banner collapse to one
        do_banner(4, 3, 0, 5, p);
        drive(0, 0);
        // Request coinciding with bonus exit is deferred
        do_banner(5, 0, 1, 6, p);
        drive(0, 0);
        do_banner(6, 0, 0, 0, p);
        bad = 0;
        repeat (6) begin
            drive(1'($urandom_range(0, 1)), 0);
            if (hero_load || freeze || banner_en) bad++;
        end
        check("no_extra_transition", bad, 0);

        // Randomized levels within range
        repeat (4) begin
            lvl = $urandom_range(0, 9);
            repeat ($urandom_range(0, 3)) drive(1'($urandom_range(0, 1)), 0);
            level = 4'(lvl);
            drive(0, 1);
            do_banner(lvl, 0, 0, 0, p);
        end

        // Reset at frame 50 of a banner
        level = 4'd2;
        drive(0, 1);
        check("mid_load", hero_load, 1);
        drive(0, 0);
        repeat (50) drive(1, 0);
        check("mid_banner", banner_en, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        #1;
        do_banner(0, 0, 0, 0, p);

        // Level above MAX_LEVEL wins
        level = 4'd10;
        drive(0, 1);
        check("win_load",  hero_load, 1);
        check("win_level", banner_level, 10);
        check("win_x",     hero_x_init, exp_x(10));
        check("win_y",     hero_y_init, exp_y(10));
        drive(0, 0);
        check("win_won",    game_won, 1);
        check("win_freeze", freeze, 1);
        check("win_banner", banner_en, 0);
        bad = 0;
        repeat (30) begin
            level = 4'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (!game_won || !freeze || hero_load || banner_en || bonus_add) bad++;
            if (banner_level != 4'd10) bad++;
        end
        check("win_sticky", bad, 0);
        #2;
        rst = 1'b0;
        #1;
        check_reset("rst_win");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/level_transition_unit.md
LEVEL_TRANSITION_UNIT -- requirements
Module: level_transition_unit

Interface
REQ-001 Parameter BANNER_FRAMES, default 120, number of frame_tick pulses the level banner stays up.
REQ-002 Parameter MAX_LEVEL, default 9, highest playable level; any level above it is the win condition.
REQ-003 Parameter BONUS_STEP, default 100, bonus points per completed level, scaled by level number.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 level  in  4  current level from the level manager, already incremented when hero_rst is seen.
REQ-007 hero_rst  in  1  one-cycle pulse from the level manager meaning the level was completed.
REQ-008 frame_tick  in  1  one-cycle pulse per video frame (vsync-derived).
REQ-009 hero_load  out  1  one-cycle pulse loading hero_x_init/hero_y_init into the hero controller.
REQ-010 hero_x_init  out  12  hero start x for banner_level.
REQ-011 hero_y_init  out  12  hero start y for banner_level.
REQ-012 freeze  out  1  high while gameplay (hero/enemy motion) must be halted.
REQ-013 banner_en  out  1  high while the "LEVEL n" banner is drawn.
REQ-014 banner_level  out  4  level number shown on the banner; also selects the start position.
REQ-015 bonus_add  out  1  one-cycle pulse; the score unit adds bonus_value.
REQ-016 bonus_value  out  24  bonus amount, valid while bonus_add is high.
REQ-017 game_won  out  1  sticky high once a level above MAX_LEVEL is reached.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, BANNER, BONUS, WIN.
- IDLE: freeze=0, banner_en=0. On hero_rst=1, capture level into banner_level and go to LOAD on the next edge.
REQ-019 LOAD SHALL last exactly one cycle.
- hero_load=1 and freeze=1.
- If banner_level > MAX_LEVEL, go to WIN; otherwise go to BANNER and clear the frame counter.
REQ-020 BANNER SHALL hold freeze=1 and banner_en=1.
- The frame counter increments only on frame_tick.
- On the frame_tick that brings the count to BANNER_FRAMES, go to BONUS.
- Count width: ceil(log2(BANNER_FRAMES+1)) bits; no wrap.
REQ-021 BONUS SHALL last one cycle.
- bonus_add=1 and bonus_value = banner_level × BONUS_STEP, zero-extended to 24 bits.
- Then go to IDLE, releasing freeze on the same edge.
REQ-022 WIN SHALL assert game_won=1 and freeze=1 and ignore all inputs until reset.
REQ-023 Latency from hero_rst to hero_load SHALL be exactly one clock.
REQ-024 hero_rst arriving outside IDLE SHALL set a one-deep pending flag.
- Further pulses while pending is set are dropped.
- On return to IDLE, a set pending flag SHALL start LOAD on the next cycle, sampling the then-current level, and clear the flag.
REQ-025 hero_rst and the BONUS exit in the same cycle SHALL be treated as pending.
REQ-026 frame_tick outside BANNER SHALL be ignored.
REQ-027 Start positions per banner_level[1:0]:
- 0 → (482,700)
- 1 → (130,700)
- 2 → (834,700)
- 3 → (482,650)
REQ-028 hero_x_init and hero_y_init SHALL be registered and stable from LOAD onward until the next capture.
REQ-029 Bonus for level 0 (game start) SHALL be 0; bonus_add SHALL still pulse.

Reset
REQ-030 While rst=0, the outputs SHALL be:
- banner_level=0, hero_x_init=482, hero_y_init=700.
- hero_load=0, freeze=1, banner_en=0, bonus_add=0, bonus_value=0, game_won=0.
- Pending flag cleared, counter cleared, state LOAD.
REQ-031 The first cycle after reset release SHALL be LOAD, so the game starts with the level-0 banner without needing hero_rst.
REQ-032 Reset asserted mid-BANNER or in WIN SHALL abort immediately to the REQ-030 values.

Structure
REQ-033 A shared package SHALL hold:
- the FSM state enumeration;
- the START_X/START_Y tables;
- default values for BANNER_FRAMES, MAX_LEVEL and BONUS_STEP.
REQ-034 Start-position lookup SHALL be a combinational sub-module, level_start_rom, indexed by level[1:0].

Verification
REQ-035 Reset release, 120 frame_ticks:
- hero_load pulses on cycle 1, banner_level=0.
- banner_en high for 120 ticks.
- bonus_add with bonus_value=0, then freeze=0.
REQ-036 level=3, hero_rst pulse in IDLE:
- hero_load the next cycle with (482,650).
- After 120 ticks, bonus_value=300.
REQ-037 Second hero_rst (level=4) during BANNER:
- The first transition completes.
- Immediately after, a new LOAD with banner_level=4 and (482,700).
REQ-038 Three hero_rst pulses during BANNER: exactly one extra transition.
REQ-039 level=10, hero_rst: LOAD, then WIN with game_won=1 and freeze=1; further hero_rst ignored.
REQ-040 rst asserted at frame 50 of BANNER: all outputs at REQ-030 values asynchronously; after release, the level-0 sequence restarts.
